// File: rtl/mem_banked_responder.sv
// Four-bank word memory with per-bank busy windows and a two-stage read pipeline.
// Requests are accepted, stalled (target bank busy) or rejected (illegal) in the same cycle.
module mem_banked_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int BANK_CYC   = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] addr,
    input  logic [15:0] data_in,
    input  logic        wr,
    input  logic        rd,
    output logic [15:0] data_out,
    output logic        rd_valid,
    output logic [3:0]  busy,
    output logic        stall,
    output logic        err
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [15:0]           mem [0:DEPTH-1];
    logic [DEPTH_LOG2-1:0] word_idx;
    logic [1:0]            bank_sel;
    logic                  req_any;
    logic                  illegal;
    logic                  accept;
    logic                  rd_accept;
    logic                  wr_accept;
    logic [15:0]           rd_word_reg;
    logic                  s1_valid_reg;

    assign word_idx  = addr[DEPTH_LOG2:1];
    assign bank_sel  = addr[2:1];
    assign req_any   = rd | wr;
    assign illegal   = (rd & wr) | (req_any & addr[0]);
    assign err       = illegal;
    assign stall     = req_any & ~illegal & busy[bank_sel];
    assign accept    = req_any & ~illegal & ~busy[bank_sel];
    assign rd_accept = accept & rd;
    assign wr_accept = accept & wr;

    // Address bits above the decoded range alias onto the same words.
    generate
        if (DEPTH_LOG2 < 15) begin : g_alias
            logic unused_addr_hi;
            assign unused_addr_hi = ^addr[15:DEPTH_LOG2+1];
        end
    endgenerate

    // Each bank owns a down-counter; busy while it is non-zero.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic [2:0] cnt_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cnt_reg <= 3'd0;
                end else if (accept && (bank_sel == 2'(gi))) begin
                    cnt_reg <= 3'(BANK_CYC);
                end else if (cnt_reg != 3'd0) begin
                    cnt_reg <= cnt_reg - 3'd1;
                end
            end

            assign busy[gi] = (cnt_reg != 3'd0);
        end
    endgenerate

    // Reads and writes never share a cycle, so the registered read always
    // sees every earlier accepted write.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[word_idx] <= data_in;
        end
        if (rd_accept) begin
            rd_word_reg <= mem[word_idx];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_reg <= 1'b0;
            rd_valid     <= 1'b0;
            data_out     <= 16'h0000;
        end else begin
            s1_valid_reg <= rd_accept;
            rd_valid     <= s1_valid_reg;
            if (s1_valid_reg) begin
                data_out <= rd_word_reg;
            end
        end
    end

endmodule

// File: tb/tb_mem_banked_responder.sv
// Scoreboard bench for mem_banked_responder: each accepted read queues its expected
// word and arrival cycle; the negedge monitor pops and compares on every rd_valid.
module tb_mem_banked_responder;

    logic        clk;
    logic        rst_n;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        rd_valid;
    logic [3:0]  busy;
    logic        stall;
    logic        err;

    typedef struct {
        logic [15:0] data;
        int          cyc;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] model_mem [0:1023];
    int          cyc;
    int          tests_run;
    int          tests_failed;

    mem_banked_responder #(
        .DEPTH_LOG2(10),
        .BANK_CYC  (4)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .addr    (addr),
        .data_in (data_in),
        .wr      (wr),
        .rd      (rd),
        .data_out(data_out),
        .rd_valid(rd_valid),
        .busy    (busy),
        .stall   (stall),
        .err     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus; stall/err/busy are checked mid-cycle.
    task automatic step(input logic r, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic es, input logic ee,
                        input logic [3:0] eb);
        exp_t e;
        @(negedge clk);
        rd = r; wr = w; addr = a; data_in = d;
        #1;
        check("stall", {31'd0, stall}, {31'd0, es});
        check("err", {31'd0, err}, {31'd0, ee});
        check("busy", {28'd0, busy}, {28'd0, eb});
        if ((r | w) && !es && !ee) begin
            if (w) begin
                model_mem[a[10:1]] = d;
            end else begin
                e.data = model_mem[a[10:1]];
                e.cyc  = cyc + 2;
                sb_q.push_back(e);
            end
        end
        $display("[TB] cyc %0d rd=%0b wr=%0b addr=%h din=%h stall=%0b err=%0b busy=%b",
                 cyc, r, w, a, d, stall, err, busy);
    endtask

    task automatic idle(input int n, input logic [3:0] eb);
        for (int i = 0; i < n; i++) begin
            step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, eb);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (rst_n && rd_valid) begin
            if (sb_q.size() == 0) begin
                check("rd_unexpected", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("rd_data", {16'd0, data_out}, {16'd0, e.data});
                check("rd_cycle", cyc, e.cyc);
                $display("[TB] cyc %0d read return data=%h", cyc, data_out);
            end
        end
    end

    initial begin
        tests_run = 0;
        tests_failed = 0;
        rst_n = 1'b0; rd = 1'b0; wr = 1'b0; addr = 16'h0; data_in = 16'h0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_busy", {28'd0, busy}, 32'd0);
        check("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
        check("rst_data_out", {16'd0, data_out}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Fill banks 2 and 3 back to back
        step(0, 1, 16'h0004, 16'hAAAA, 0, 0, 4'b0000);
        step(0, 1, 16'h0006, 16'h5555, 0, 0, 4'b0100);
        idle(3, 4'b1100);
        idle(1, 4'b1000);
        idle(1, 4'b0000);

        // Write then read bank 1 once its busy window closes
        step(0, 1, 16'h0002, 16'hBEEF, 0, 0, 4'b0000);
        idle(4, 4'b0010);
        step(1, 0, 16'h0002, 16'h0000, 0, 0, 4'b0000);
        idle(4, 4'b0010);
        idle(1, 4'b0000);

        // Held write to a busy bank stalls until the window ends
        step(0, 1, 16'h0000, 16'h1111, 0, 0, 4'b0000);
        for (int i = 0; i < 4; i++) step(0, 1, 16'h0000, 16'h2222, 1, 0, 4'b0001);
        step(0, 1, 16'h0000, 16'h2222, 0, 0, 4'b0000);
        idle(4, 4'b0001);
        idle(1, 4'b0000);

        // Back-to-back reads across all banks, two in flight at a time
        step(1, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000);
        step(1, 0, 16'h0002, 16'h0000, 0, 0, 4'b0001);
        step(1, 0, 16'h0004, 16'h0000, 0, 0, 4'b0011);
        step(1, 0, 16'h0006, 16'h0000, 0, 0, 4'b0111);
        idle(1, 4'b1111);
        idle(1, 4'b1110);
        idle(1, 4'b1100);
        idle(1, 4'b1000);
        idle(1, 4'b0000);

        // Illegal requests: err wins over stall, and nothing changes
        step(0, 1, 16'h0000, 16'h3333, 0, 0, 4'b0000);
        step(1, 1, 16'h0000, 16'hFFFF, 0, 1, 4'b0001);
        step(1, 0, 16'h0003, 16'h0000, 0, 1, 4'b0001);
        step(1, 1, 16'h0002, 16'hFFFF, 0, 1, 4'b0001);
        idle(1, 4'b0001);
        idle(1, 4'b0000);
        step(0, 1, 16'h0005, 16'hFFFF, 0, 1, 4'b0000);
        idle(1, 4'b0000);

        // Upper address bits alias
        step(0, 1, 16'h0800, 16'h1234, 0, 0, 4'b0000);
        idle(4, 4'b0001);
        step(1, 0, 16'h0000, 16'h0000, 0, 0, 4'b0000);
        idle(4, 4'b0001);
        idle(1, 4'b0000);

        // Reset while a read is in flight drops it
        step(1, 0, 16'h0004, 16'h0000, 0, 0, 4'b0000);
        @(negedge clk);
        rd = 1'b0;
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {28'd0, busy}, 32'd0);
        check("midrst_data_out", {16'd0, data_out}, 32'd0);
        check("midrst_rd_valid", {31'd0, rd_valid}, 32'd0);
        sb_q.delete();
        $display("[TB] cyc %0d reset asserted mid-read", cyc);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 4'b0000);

        // Array survives reset; first request after reset behaves normally
        step(1, 0, 16'h0002, 16'h0000, 0, 0, 4'b0000);
        idle(4, 4'b0010);
        idle(2, 4'b0000);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
